// File: rtl/lcd_cmd_driver.sv
// lcd_cmd_driver: turns LSU LCD-register GO requests into timed HD44780 write cycles.
// Define LCD_INIT_EN to add a power-up wait plus automatic init sequence per ON session.
module lcd_cmd_driver #(
    parameter int T_SETUP_CYC = 4,
    parameter int T_EN_CYC    = 25,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_EXEC_CYC  = 2000,
    parameter int T_LONG_CYC  = 82000,
    parameter int T_PWRUP_CYC = 750000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_io_lcd,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_busy,
    output logic        o_lcd_drop
);
    function automatic int max2(int a, int b);
        return a > b ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_SETUP_CYC, T_EN_CYC), max2(T_HOLD_CYC, T_EXEC_CYC)),
                                max2(T_LONG_CYC, T_PWRUP_CYC));
    localparam int CW = $clog2(T_MAX) + 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, PULSE, HOLD, EXEC
`ifdef LCD_INIT_EN
        , PWRUP, INIT_LOAD
`endif
    } state_t;

    state_t        r_state;
    logic [31:0]   r_lcd;
    logic          r_go_prev;
    logic [CW-1:0] r_cnt;
    logic          w_go_edge, w_long, w_init_start, w_unused_lcd;

    assign w_go_edge    = r_lcd[10] & ~r_go_prev;
    assign w_long       = !o_lcd_rs && o_lcd_data[7:2] == 6'd0 && o_lcd_data != 8'd0;
    assign w_unused_lcd = &{r_lcd[30:11], r_lcd[8]};
    assign o_lcd_rw     = 1'b0;

`ifdef LCD_INIT_EN
    logic       r_init_done, r_in_init;
    logic [1:0] r_init_idx;
    logic [7:0] w_init_cmd;
    assign w_init_start = r_lcd[31] & ~r_init_done;
    assign w_init_cmd   = r_init_idx == 2'd0 ? 8'h38 :
                          r_init_idx == 2'd1 ? 8'h0C :
                          r_init_idx == 2'd2 ? 8'h01 : 8'h06;
`else
    assign w_init_start = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lcd      <= '0;
            r_go_prev  <= 1'b0;
            r_cnt      <= '0;
            r_state    <= IDLE;
            o_lcd_on   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'd0;
            o_lcd_busy <= 1'b0;
            o_lcd_drop <= 1'b0;
`ifdef LCD_INIT_EN
            r_init_done <= 1'b0;
            r_in_init   <= 1'b0;
            r_init_idx  <= 2'd0;
`endif
        end else begin
            r_lcd     <= i_io_lcd;
            r_go_prev <= r_lcd[10];
            o_lcd_on  <= r_lcd[31];
            if (!r_lcd[31])
                o_lcd_drop <= 1'b0;
            else if (w_go_edge && (r_state != IDLE || w_init_start))
                o_lcd_drop <= 1'b1;
`ifdef LCD_INIT_EN
            if (!r_lcd[31]) begin
                r_init_done <= 1'b0;
                r_in_init   <= 1'b0;
            end
`endif
            if (r_cnt != '0)
                r_cnt <= r_cnt - CW'(1);
            // ON falling aborts any transaction; the bus keeps its last RS/DATA
            if (r_state != IDLE && !r_lcd[31]) begin
                r_state    <= IDLE;
                o_lcd_en   <= 1'b0;
                o_lcd_busy <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
`ifdef LCD_INIT_EN
                        if (w_init_start) begin
                            r_state    <= PWRUP;
                            o_lcd_busy <= 1'b1;
                            r_in_init  <= 1'b1;
                            r_init_idx <= 2'd0;
                            r_cnt      <= CW'(T_PWRUP_CYC - 1);
                        end else
`endif
                        if (w_go_edge && r_lcd[31]) begin
                            o_lcd_rs   <= r_lcd[9];
                            o_lcd_data <= r_lcd[7:0];
                            o_lcd_busy <= 1'b1;
                            r_cnt      <= CW'(T_SETUP_CYC - 1);
                            r_state    <= SETUP;
                        end
                    end
                    SETUP: if (r_cnt == '0) begin
                        o_lcd_en <= 1'b1;
                        r_cnt    <= CW'(T_EN_CYC - 1);
                        r_state  <= PULSE;
                    end
                    PULSE: if (r_cnt == '0) begin
                        o_lcd_en <= 1'b0;
                        r_cnt    <= CW'(T_HOLD_CYC - 1);
                        r_state  <= HOLD;
                    end
                    HOLD: if (r_cnt == '0) begin
                        r_cnt   <= w_long ? CW'(T_LONG_CYC - 1) : CW'(T_EXEC_CYC - 1);
                        r_state <= EXEC;
                    end
                    EXEC: if (r_cnt == '0) begin
`ifdef LCD_INIT_EN
                        if (r_in_init && r_init_idx != 2'd3) begin
                            r_init_idx <= r_init_idx + 2'd1;
                            r_state    <= INIT_LOAD;
                        end else begin
                            r_init_done <= r_init_done | r_in_init;
                            r_in_init   <= 1'b0;
                            r_state     <= IDLE;
                            o_lcd_busy  <= 1'b0;
                        end
`else
                        r_state    <= IDLE;
                        o_lcd_busy <= 1'b0;
`endif
                    end
`ifdef LCD_INIT_EN
                    PWRUP: if (r_cnt == '0) r_state <= INIT_LOAD;
                    INIT_LOAD: begin
                        o_lcd_rs   <= 1'b0;
                        o_lcd_data <= w_init_cmd;
                        r_cnt      <= CW'(T_SETUP_CYC - 1);
                        r_state    <= SETUP;
                    end
`endif
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule
